// File: rtl/pushbutton_edge_slave.sv
// ---------------------------------------------------------------------------
// pushbutton_edge_slave
//
// Avalon-MM slave that turns raw active-low pushbuttons (KEY[3:0] on the
// board) into a debounced press state, latched press events, a maskable
// level interrupt and an optional 16-bit press counter for the Nios II CPU.
//
// Build option:
//   PB_PRESS_COUNTER_EN  - when defined, the COUNT register (word 3) and its
//                          16-bit wrapping press counter are built. When
//                          undefined, no counter logic exists and word 3
//                          reads as zero.
//
// Parameters:
//   WIDTH            number of pushbutton inputs (1..16)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new level (>= 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   avs_address    word address (0 DATA, 1 MASK, 2 EDGE, 3 COUNT)
//   avs_read       read strobe, data returned on avs_readdata one cycle later
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, holds its value between reads
//   irq            registered level interrupt, |(EDGE & MASK)
//   key_in         raw pushbuttons, active-low, asynchronous to clk
// ---------------------------------------------------------------------------
module pushbutton_edge_slave #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] key_in
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  // Terminal count: the level is accepted on the cycle the counter would
  // otherwise step past DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer stage boundary: raw key_in -> key_s1_q -> key_s2_q
  logic [WIDTH-1:0] key_s1_q, key_s1_d;
  logic [WIDTH-1:0] key_s2_q, key_s2_d;

  // Debounce stage boundary: key_s2_q -> db_q / cnt_q
  logic [WIDTH-1:0] key_act;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] rise;

  // Register stage boundary: db/rise + bus -> edge_q, mask_q, irq_q, readdata_q
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_clr;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      rd_word;
  logic             wr_mask;
  logic             wr_edge;

  // Writedata bits above WIDTH have no destination in any register.
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, avs_writedata};

  // -------------------------------------------------------------------------
  // Synchronizer
  // -------------------------------------------------------------------------
  always_comb begin
    key_s1_d = key_in;
    key_s2_d = key_s1_q;
  end

  // Inverted so the debouncer works in pressed-high terms.
  assign key_act = ~key_s2_q;

  // -------------------------------------------------------------------------
  // Debounce: a per-bit run-length counter of cycles where the synchronized
  // input disagrees with the accepted state. Any agreement restarts the run.
  // -------------------------------------------------------------------------
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (key_act[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press event is taken from the next-state value so EDGE sets on the same
  // clock edge that db rises.
  assign rise = db_d & ~db_q;

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  assign wr_mask = avs_write && (avs_address == ADDR_MASK);
  assign wr_edge = avs_write && (avs_address == ADDR_EDGE);

  always_comb begin
    edge_clr = wr_edge ? avs_writedata[WIDTH-1:0] : '0;
    // Clear first, then set: a press in the same cycle as a clear wins.
    edge_d   = (edge_q & ~edge_clr) | rise;
    mask_d   = wr_mask ? avs_writedata[WIDTH-1:0] : mask_q;
    irq_d    = |(edge_q & mask_q);
  end

`ifdef PB_PRESS_COUNTER_EN
  // -------------------------------------------------------------------------
  // Press counter: adds the number of simultaneous press events, wraps at 16b
  // -------------------------------------------------------------------------
  logic [15:0] count_q, count_d;
  logic [15:0] press_num;

  always_comb begin
    press_num = '0;
    for (int i = 0; i < WIDTH; i++) begin
      press_num = press_num + 16'(rise[i]);
    end
    count_d = count_q + press_num;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

  // Read mux samples current (pre-write) register values.
  always_comb begin
    rd_word = '0;
    case (avs_address)
      ADDR_DATA:  rd_word = 32'(db_q);
      ADDR_MASK:  rd_word = 32'(mask_q);
      ADDR_EDGE:  rd_word = 32'(edge_q);
      ADDR_COUNT: begin
`ifdef PB_PRESS_COUNTER_EN
        rd_word = 32'(count_q);
`else
        rd_word = '0;
`endif
      end
      default:    rd_word = '0;
    endcase
    readdata_d = avs_read ? rd_word : readdata_q;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      db_q       <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      db_q       <= db_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pushbutton_edge_slave.sv
module tb_pushbutton_edge_slave;

  localparam int WIDTH = 4;
  localparam int DB    = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             reset_n;
  logic [1:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic             irq;
  logic [WIDTH-1:0] key_in;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   presses  = 0;

  pushbutton_edge_slave #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq),
    .key_in(key_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef PB_PRESS_COUNTER_EN
    return 32'(presses & 16'hFFFF);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the read is captured on the next posedge and the
  // scoreboard entry is retired at the following negedge.
  task automatic do_rw(input logic [1:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    avs_address   = addr;
    avs_read      = 1'b1;
    avs_write     = wr;
    avs_writedata = wdata;
    @(posedge clk);
    @(negedge clk);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    e = sb_q.pop_front();
    check_eq(e.tag, avs_readdata, e.exp);
  endtask

  task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    do_rw(addr, 1'b0, 32'd0, exp, tag);
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] wdata);
    avs_address   = addr;
    avs_write     = 1'b1;
    avs_writedata = wdata;
    @(posedge clk);
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    key_in        = 4'h0;
    avs_address   = 2'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'd0;

    // Reset state
    tick(3);
    check_eq("rst_rdata", avs_readdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    key_in  = 4'hF;
    reset_n = 1'b1;
    tick(3);
    do_read(2'd0, 32'd0, "rst_data");
    do_read(2'd1, 32'd0, "rst_mask");
    do_read(2'd2, 32'd0, "rst_edge");
    do_read(2'd3, 32'd0, "rst_count");

    // Clean press of key 2: db updates on the 10th edge after first sample
    key_in = 4'b1011;
    tick(9);
    do_read(2'd0, 32'd0, "press_data_e10");
    presses++;
    do_read(2'd0, 32'h4, "press_data_e11");
    do_read(2'd2, 32'h4, "press_edge");
    tick(2);
    check_eq("rdata_hold", avs_readdata, 32'h4);
    do_read(2'd3, cnt_exp(), "press_count1");
    key_in = 4'hF;
    tick(12);
    do_read(2'd0, 32'h0, "release_data");
    do_read(2'd2, 32'h4, "release_edge");
    do_write(2'd2, 32'h4);
    do_read(2'd2, 32'h0, "edge_cleared");
    do_write(2'd0, 32'hF);
    do_read(2'd0, 32'h0, "data_ro");

    // Bounce rejection on key 0
    key_in = 4'b1110; tick(5);
    key_in = 4'b1111; tick(3);
    key_in = 4'b1110; tick(7);
    key_in = 4'b1111; tick(12);
    do_read(2'd0, 32'h0, "bounce_data");
    do_read(2'd2, 32'h0, "bounce_edge");
    key_in = 4'b1110; tick(12);
    presses++;
    do_read(2'd2, 32'h1, "stable_edge");
    do_read(2'd0, 32'h1, "stable_data");
    key_in = 4'hF; tick(12);
    do_write(2'd2, 32'h1);
    do_read(2'd2, 32'h0, "edge_cleared2");

    // Interrupt flow
    do_write(2'd1, 32'hFFFF_FFF3);
    do_read(2'd1, 32'h3, "mask_upper_ignored");
    key_in = 4'b1101;
    tick(10);
    check_eq("irq_before", {31'd0, irq}, 32'd0);
    tick(1);
    check_eq("irq_rise", {31'd0, irq}, 32'd1);
    presses++;
    do_read(2'd2, 32'h2, "irq_edge");
    do_write(2'd2, 32'h2);
    check_eq("irq_hold", {31'd0, irq}, 32'd1);
    tick(1);
    check_eq("irq_fall", {31'd0, irq}, 32'd0);
    key_in = 4'hF; tick(12);
    key_in = 4'b0111; tick(14);
    presses++;
    check_eq("irq_masked", {31'd0, irq}, 32'd0);
    do_read(2'd2, 32'h8, "masked_edge");
    key_in = 4'hF; tick(12);
    do_write(2'd2, 32'h8);
    key_in = 4'b1110; tick(14);
    presses++;
    check_eq("irq_key0", {31'd0, irq}, 32'd1);
    do_write(2'd1, 32'h0);
    check_eq("irq_mask_hold", {31'd0, irq}, 32'd1);
    tick(1);
    check_eq("irq_mask_fall", {31'd0, irq}, 32'd0);
    key_in = 4'hF; tick(12);
    do_write(2'd2, 32'h1);

    // Set/clear collision on EDGE[0]
    key_in = 4'b1110;
    tick(9);
    do_write(2'd2, 32'h1);
    presses++;
    do_read(2'd2, 32'h1, "collide_edge");
    do_rw(2'd2, 1'b1, 32'h1, 32'h1, "rw_pre_value");
    do_read(2'd2, 32'h0, "rw_post_value");
    key_in = 4'hF; tick(12);
    do_read(2'd3, cnt_exp(), "count_six");

    // Four simultaneous presses
    key_in = 4'h0; tick(12);
    presses += 4;
    do_read(2'd2, 32'hF, "all_edge");
    do_read(2'd3, cnt_exp(), "count_all");
    key_in = 4'hF; tick(12);
    do_write(2'd2, 32'hF);

    // Counter wrap
`ifdef PB_PRESS_COUNTER_EN
    force dut.count_q = 16'hFFFF;
    tick(1);
    release dut.count_q;
    do_read(2'd3, 32'hFFFF, "count_forced");
    key_in = 4'b1110; tick(12);
    do_read(2'd3, 32'h0, "count_wrap");
`else
    key_in = 4'b1110; tick(12);
    do_read(2'd3, 32'h0, "count_off");
`endif
    key_in = 4'hF; tick(12);
    do_write(2'd2, 32'h1);

    // Asynchronous reset mid-operation
    do_write(2'd1, 32'h1);
    key_in = 4'b1110; tick(14);
    check_eq("pre_rst_irq", {31'd0, irq}, 32'd1);
    do_read(2'd2, 32'h1, "pre_rst_edge");
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_rdata", avs_readdata, 32'd0);
    check_eq("async_rst_irq", {31'd0, irq}, 32'd0);
    key_in = 4'hF;
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    do_read(2'd1, 32'h0, "post_rst_mask");
    do_read(2'd2, 32'h0, "post_rst_edge");
    do_read(2'd0, 32'h0, "post_rst_data");
    do_read(2'd3, 32'h0, "post_rst_count");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pushbutton_edge_slave.md
# pushbutton_edge_slave

Avalon-MM slave that turns the board's raw active-low KEY inputs into debounced press state, latched press events, a maskable interrupt and an optional press counter for the Nios II processor. It is the CPU-facing input side that complements the existing output PIOs for HEX, LEDG and LEDR. It instantiates inside the Qsys system, with its conduit going to KEY[3:0] at the board top level.

## Interface
- WIDTH, 4, number of pushbutton inputs (1..16)
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz); must be ≥ 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  2  word address of the register
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid one cycle after avs_read
- irq  out  1  level interrupt, active high
- key_in  in  WIDTH  raw pushbuttons, active-low (0 = pressed), asynchronous to clk

## Operation
- Synchronizer: 2-FF chain per bit. Both stages reset to 1 (released).
- Debounce, per bit:
  - The debounced state `db[i]` is stored active-high (1 = pressed).
  - Each bit compares its synchronized, inverted input with `db[i]`.
  - If they are equal, the counter clears to 0.
  - If they differ and the counter equals DEBOUNCE_CYCLES-1, `db[i]` toggles and the counter clears.
  - If they differ otherwise, the counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Press event: `db[i]` going 0→1 sets `edge[i]` in the same clock edge that `db[i]` updates. Releases (1→0) set nothing.
- Register map (word addresses):
  - 0, DATA: RO. Bits [WIDTH-1:0] = db; upper bits 0.
  - 1, MASK: RW. Bits [WIDTH-1:0]; writes to upper bits are ignored and they read 0.
  - 2, EDGE: Read returns edge. Writing 1 clears that bit; writing 0 leaves it.
  - 3, COUNT: RO. 16-bit total press count in bits [15:0], zero-extended. Wraps 0xFFFF→0x0000.
- COUNT increments by the number of bits with a press event in that cycle. With WIDTH=4, a cycle with four simultaneous presses adds 4.
- Simultaneous set and clear of the same EDGE bit: set wins, so the bit reads 1.
- Writes to DATA and COUNT are ignored.
- irq is registered: irq <= |(edge & mask).
- Simultaneous avs_read and avs_write: both are performed. Read data reflects the pre-write value.

## Timing
- Reset values: avs_readdata=0, irq=0, db=0, edge=0, mask=0, count=0, debounce counters=0.
- Reset is asynchronous. Assertion mid-debounce or mid-read discards all state immediately. No read response is issued for a read that was in flight at reset.
- Debounce latency: a clean level change on key_in is reflected in db and edge exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled.
- irq latency:
  - irq asserts 1 cycle after edge&mask becomes non-zero.
  - irq deasserts 1 cycle after the clearing write, or after the MASK write that removes the last set bit.
- Read latency is fixed at 1 (Avalon readLatency=1, no waitrequest). avs_readdata holds its last value when no read is issued.
- Writes take effect at the clock edge where avs_write=1. A read of the same register in the following cycle returns the new value.

## Configuration
- PB_PRESS_COUNTER_EN defined:
  - The COUNT register and its 16-bit counter are built.
- PB_PRESS_COUNTER_EN undefined:
  - The counter logic is not built.
  - Reads of address 3 return 0.
  - All other behaviour is identical.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8.

- Reset check: hold reset_n=0 with key_in=4'b0000, then release with key_in=4'hF. → avs_readdata=0 and irq=0; reads of DATA, MASK, EDGE and COUNT all return 0.
- Clean press: drive key_in[2]=0 and hold it. → DATA reads 0x4 starting 10 edges after the first sample; EDGE reads 0x4; COUNT reads 1. Releasing key_in[2] → DATA=0, EDGE stays 0x4.
- Bounce rejection: toggle key_in[0] low for 5 cycles, high for 3, then low for 7. → db[0] stays 0 and EDGE=0. Only after a low period of 8+ stable cycles does EDGE read 0x1.
- Interrupt flow:
  - Write MASK=0x3, then press key 1. → irq rises 1 cycle after EDGE[1] sets.
  - Write EDGE=0x2. → irq falls 1 cycle later.
  - Press key 3 with MASK=0x3. → irq stays 0.
- Set/clear collision: time a write of EDGE=0x1 in the same cycle that db[0] rises. → EDGE reads 0x1.
- Counter wrap (PB_PRESS_COUNTER_EN defined): force count to 0xFFFF, then press key 0. → COUNT=0x0000. The same press with the macro undefined → address 3 reads 0.
